// File: rtl/counter_link_pkg.sv
// Shared types and constants for the counter snapshot frame link.
package counter_link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int FRAME_LEN = 18;
    localparam int IDX_W     = 5;

    localparam logic [7:0] HEADER_DFLT = 8'hA5;

    // Byte positions within a frame
    localparam logic [IDX_W-1:0] IDX_HDR      = 5'd0;
    localparam logic [IDX_W-1:0] IDX_C0_FIRST = 5'd1;
    localparam logic [IDX_W-1:0] IDX_C1_FIRST = 5'd9;
    localparam logic [IDX_W-1:0] IDX_CSUM     = IDX_W'(FRAME_LEN - 1);

    // XOR of the eight bytes of a 64-bit word
    function automatic logic [7:0] xor_bytes(input logic [63:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ v[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/counter_frame_tx_if.sv
// Byte-wide valid/ready stream carrying snapshot frames.
interface counter_frame_tx_if;
    logic [7:0] Data;
    logic       Valid;
    logic       Last;
    logic       Ready;

    modport master (output Data, output Valid, output Last, input Ready);
    modport slave  (input Data, input Valid, input Last, output Ready);
endinterface

// File: rtl/frame_byte_sel.sv
// Maps a frame byte index onto the captured snapshot contents.
module frame_byte_sel
    import counter_link_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DFLT
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      cnt0,
    input  logic [63:0]      cnt1,
    input  logic [7:0]       csum,
    output logic [7:0]       data
);

    logic [2:0] b0;
    logic [2:0] b1;

    // Counters go out MSB first: index 1 (or 9) picks byte 7 of the word
    always_comb begin
        b0   = 3'(5'd8 - idx);
        b1   = 3'(5'd16 - idx);
        data = 8'h00;
        if (idx == IDX_HDR)
            data = HEADER;
        else if (idx >= IDX_C0_FIRST && idx < IDX_C1_FIRST)
            data = 8'(cnt0 >> {b0, 3'b000});
        else if (idx >= IDX_C1_FIRST && idx < IDX_CSUM)
            data = 8'(cnt1 >> {b1, 3'b000});
        else if (idx == IDX_CSUM)
            data = csum;
    end

endmodule

// File: rtl/counter_frame_tx.sv
// Captures both 64-bit counters on Snap and streams an 18-byte frame.
module counter_frame_tx
    import counter_link_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DFLT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [63:0]        Count0,
    input  logic [63:0]        Count1,
    input  logic               Snap,
    counter_frame_tx_if.master bus,
    output logic               Busy,
    output logic               Overrun
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [63:0]      cnt0_q, cnt1_q;
    logic [7:0]       csum_q;
    logic             load;
    logic [7:0]       sel_byte;

    // State and index registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next state; a transfer at the checksum byte ends the frame
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (Snap) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.Ready) begin
                    if (idx == IDX_CSUM) begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot capture: both counters and their checksum on the same edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            csum_q <= '0;
        end else if (load) begin
            cnt0_q <= Count0;
            cnt1_q <= Count1;
            csum_q <= xor_bytes(Count0) ^ xor_bytes(Count1);
        end
    end

    // Sticky overrun: a Snap that could not start a frame
    always_ff @(posedge Clk) begin
        if (Reset)
            Overrun <= 1'b0;
        else if (state == IDLE && Snap)
            Overrun <= 1'b0;
        else if (state == SEND && Snap)
            Overrun <= 1'b1;
    end

    frame_byte_sel #(.HEADER(HEADER)) u_sel (
        .idx  (idx),
        .cnt0 (cnt0_q),
        .cnt1 (cnt1_q),
        .csum (csum_q),
        .data (sel_byte)
    );

    // Outputs decode registered state only; Data idles at zero
    always_comb begin
        bus.Valid = (state == SEND);
        bus.Data  = bus.Valid ? sel_byte : 8'h00;
        bus.Last  = bus.Valid && (idx == IDX_CSUM);
        Busy      = bus.Valid;
    end

endmodule
